// File: rtl/gb_serial_pkg.sv
// gb_serial_pkg: register address codes, SC bit positions, FSM encoding and default divider for gb_serial.
package gb_serial_pkg;
  localparam int CLK_DIV_DEF = 512;
  localparam logic [1:0] SB_ADDR = 2'b01;
  localparam logic [1:0] SC_ADDR = 2'b10;
  localparam int SC_START = 7;
  localparam int SC_CLKSEL = 0;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/gb_serial_sync.sv
// gb_serial_sync: 2-flop synchronizer for an asynchronous input plus one-clk rise/fall pulses.
module gb_serial_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] r;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r <= '1;
    else r <= {r[1:0], d};
  assign q = r[1];
  assign rise = r[1] & ~r[2];
  assign fall = ~r[1] & r[2];
endmodule

// File: rtl/gb_serial.sv
// gb_serial: Game Boy serial port (SB/SC registers, 8-bit shift transfer, completion irq).
// Define GB_SERIAL_EXTCLK_EN to enable external-clock (sclk_in) transfers.
module gb_serial
  import gb_serial_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_sel,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       irq,
  input  logic       sclk_in,
  input  logic       sd_in,
  output logic       sclk_out,
  output logic       sclk_oe,
  output logic       sd_out
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] FALL_AT = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] RISE_AT = DW'(CLK_DIV - 1);
  state_t state, state_nx;
  logic [7:0] sb;
  logic [DW-1:0] div;
  logic [2:0] cnt;
  logic clksel, sd_s, sd_lat, sc_wr, sb_wr, shifting, fall_ev, rise_ev, done, ext_rise, ext_fall;
  logic unused_sd_rise, unused_sd_fall;
  gb_serial_sync u_sd (
    .clk(clk), .reset_n(reset_n), .d(sd_in), .q(sd_s), .rise(unused_sd_rise), .fall(unused_sd_fall)
  );
`ifdef GB_SERIAL_EXTCLK_EN
  logic unused_sclk_q;
  gb_serial_sync u_sclk (
    .clk(clk), .reset_n(reset_n), .d(sclk_in), .q(unused_sclk_q), .rise(ext_rise), .fall(ext_fall)
  );
`else
  logic unused_sclk;
  assign unused_sclk = sclk_in;
  assign ext_rise = 1'b0;
  assign ext_fall = 1'b0;
`endif
  assign sc_wr = cpu_sel & cpu_wr & (cpu_addr == SC_ADDR);
  assign sb_wr = cpu_sel & cpu_wr & (cpu_addr == SB_ADDR);
  assign shifting = state == SHIFT;
  // An SC write in the same cycle pre-empts any serial edge.
  assign fall_ev = shifting & ~sc_wr & (clksel ? (div == FALL_AT) : ext_fall);
  assign rise_ev = shifting & ~sc_wr & (clksel ? (div == RISE_AT) : ext_rise);
  assign done = rise_ev & (cnt == 3'd7);
  assign cpu_do = cpu_addr == SB_ADDR ? sb : cpu_addr == SC_ADDR ? {shifting, 6'h3F, clksel} : 8'hFF;
  assign sd_out = sb[7];
  assign sclk_oe = clksel;
  always_comb state_nx = sc_wr ? (cpu_di[SC_START] ? SHIFT : IDLE) : done ? IDLE : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // sd_in is captured while the outgoing bit is still on sd_out, so a loopback returns the byte intact.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sb <= '0;
      div <= '0;
      cnt <= '0;
      clksel <= 1'b0;
      irq <= 1'b0;
      sclk_out <= 1'b1;
      sd_lat <= 1'b1;
    end else begin
      irq <= done;
      if (sc_wr) clksel <= cpu_di[SC_CLKSEL];
      if (sc_wr | ~shifting) begin
        div <= '0;
        sclk_out <= 1'b1;
      end else begin
        if (clksel) div <= rise_ev ? '0 : div + 1'b1;
        if (fall_ev & clksel) sclk_out <= 1'b0;
        else if (rise_ev) sclk_out <= 1'b1;
      end
      if (sc_wr & cpu_di[SC_START]) cnt <= '0;
      else if (rise_ev) cnt <= cnt + 1'b1;
      if (fall_ev) sd_lat <= sd_s;
      if (sb_wr) sb <= cpu_di;
      else if (fall_ev) sb <= {sb[6:0], 1'b0};
      else if (rise_ev) sb[0] <= sd_lat;
    end
endmodule

// File: tb/tb_gb_serial.sv
// tb_gb_serial: scoreboard bench for gb_serial; expected irq cycles and sd_out bits are queued at stimulus time.
module tb_gb_serial;
  import gb_serial_pkg::*;
  localparam int CLK_DIV = 512;
  localparam int XFER = 8 * CLK_DIV;
  typedef struct {int lo; int hi;} win_t;
  logic clk = 0, reset_n = 0, cpu_sel = 0, cpu_wr = 0, sclk_in = 1, loop = 0, sd_drv = 1;
  logic [1:0] cpu_addr = 0;
  logic [7:0] cpu_di = 0, cpu_do;
  logic irq, sd_in, sclk_out, sclk_oe, sd_out;
  logic prev_sclk = 1, prev_sd = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0, irq_n = 0;
  win_t irq_q[$];
  logic bit_q[$];
  assign sd_in = loop ? sd_out : sd_drv;
  gb_serial #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_di(cpu_di), .cpu_do(cpu_do), .irq(irq), .sclk_in(sclk_in), .sd_in(sd_in),
    .sclk_out(sclk_out), .sclk_oe(sclk_oe), .sd_out(sd_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    win_t w;
    if (reset_n) begin
      if (irq) begin
        irq_n++;
        if (irq_q.size() == 0) chk("irq_unexpected", 1, 0);
        else begin
          w = irq_q.pop_front();
          chk("irq_cycle", (cyc >= w.lo && cyc <= w.hi) ? w.lo : cyc, w.lo);
        end
      end
      if (prev_sclk && !sclk_out && bit_q.size() != 0) chk("sd_out_bit", prev_sd, bit_q.pop_front());
    end
    prev_sclk = sclk_out;
    prev_sd = sd_out;
  end
  task automatic drive(input logic [1:0] a, input logic [7:0] d);
    cpu_sel = 1; cpu_wr = 1; cpu_addr = a; cpu_di = d;
    @(negedge clk);
    cpu_sel = 0; cpu_wr = 0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    drive(a, d);
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1 d = cpu_do;
  endtask
  task automatic push_irq(input int lo, input int hi);
    win_t w;
    w.lo = lo; w.hi = hi;
    irq_q.push_back(w);
  endtask
  task automatic push_bits(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) bit_q.push_back(p[i]);
  endtask
  task automatic wait_irq(input int budget);
    int n0, i;
    n0 = irq_n; i = 0;
    while (irq_n == n0 && i < budget) begin
      @(negedge clk);
      #1 i++;
    end
    chk("irq_timeout", irq_n != n0, 1);
  endtask
  initial begin
    logic [7:0] v;
    int n0;
    repeat (3) @(negedge clk);
    rd(SB_ADDR, v); chk("rst_sb", v, 8'h00);
    rd(SC_ADDR, v); chk("rst_sc", v, 8'h7E);
    rd(2'b00, v); chk("rd_addr00", v, 8'hFF);
    rd(2'b11, v); chk("rd_addr11", v, 8'hFF);
    chk("rst_sclk_out", sclk_out, 1); chk("rst_sclk_oe", sclk_oe, 0);
    chk("rst_irq", irq, 0); chk("rst_sd_out", sd_out, 0);
    @(negedge clk); reset_n = 1;
    // internal clock, sd_in held high
    wr(SB_ADDR, 8'hA5); rd(SB_ADDR, v); chk("sb_write", v, 8'hA5); chk("sd_out_msb", sd_out, 1);
    push_bits(8'hA5);
    wr(SC_ADDR, 8'h81); push_irq(cyc + XFER, cyc + XFER);
    rd(SC_ADDR, v); chk("sc_busy", v, 8'hFF); chk("sclk_oe_int", sclk_oe, 1);
    wait_irq(XFER + 16);
    chk("a5_bits_left", bit_q.size(), 0);
    rd(SB_ADDR, v); chk("a5_sb_final", v, 8'hFF);
    rd(SC_ADDR, v); chk("a5_sc_final", v, 8'h7F);
    // loopback
    loop = 1; n0 = irq_n;
    wr(SB_ADDR, 8'h3C); push_bits(8'h3C);
    wr(SC_ADDR, 8'h81); push_irq(cyc + XFER, cyc + XFER);
    wait_irq(XFER + 16);
    rd(SB_ADDR, v); chk("loop_sb", v, 8'h3C);
    repeat (XFER) @(negedge clk);
    chk("loop_irq_count", irq_n - n0, 1);
    loop = 0;
    // abort at cycle 1000
    n0 = irq_n;
    wr(SC_ADDR, 8'h81);
    repeat (999) @(negedge clk);
    drive(SC_ADDR, 8'h01);
    rd(SC_ADDR, v); chk("abort_sc", v, 8'h7F); chk("abort_sclk_out", sclk_out, 1);
    repeat (2 * XFER) @(negedge clk);
    chk("abort_no_irq", irq_n - n0, 0); chk("abort_sclk_idle", sclk_out, 1);
    // SB write on the first rising serial edge
    wr(SC_ADDR, 8'h81); push_irq(cyc + XFER, cyc + XFER);
    repeat (CLK_DIV - 1) @(negedge clk);
    drive(SB_ADDR, 8'h5A);
    rd(SB_ADDR, v); chk("sb_wr_on_rise", v, 8'h5A);
    wait_irq(XFER);
    rd(SB_ADDR, v); chk("sb_wr_on_rise_final", v, 8'h7F);
    // reset mid-transfer
    wr(SB_ADDR, 8'hC3); wr(SC_ADDR, 8'h81);
    repeat (2000) @(negedge clk);
    reset_n = 0;
    rd(SB_ADDR, v); chk("midrst_sb", v, 8'h00);
    rd(SC_ADDR, v); chk("midrst_sc", v, 8'h7E);
    chk("midrst_sclk_out", sclk_out, 1); chk("midrst_irq", irq, 0); chk("midrst_oe", sclk_oe, 0);
    n0 = irq_n;
    @(negedge clk); reset_n = 1;
    repeat (2 * XFER) @(negedge clk);
    chk("midrst_no_irq", irq_n - n0, 0);
    rd(SC_ADDR, v); chk("midrst_sc_after", v, 8'h7E);
`ifdef GB_SERIAL_EXTCLK_EN
    n0 = irq_n;
    wr(SB_ADDR, 8'h00); wr(SC_ADDR, 8'h80);
    rd(SC_ADDR, v); chk("ext_sc_busy", v, 8'hFE); chk("ext_sclk_oe", sclk_oe, 0);
    for (int i = 0; i < 8; i++) begin
      sclk_in = 0;
      repeat (20) @(negedge clk);
      sclk_in = 1;
      if (i == 7) push_irq(cyc + 1, cyc + 6);
      repeat (20) @(negedge clk);
    end
    chk("ext_irq_count", irq_n - n0, 1);
    rd(SB_ADDR, v); chk("ext_sb", v, 8'hFF);
    rd(SC_ADDR, v); chk("ext_sc_done", v, 8'h7E);
    chk("ext_sclk_out", sclk_out, 1);
`else
    n0 = irq_n;
    wr(SC_ADDR, 8'h80);
    for (int i = 0; i < 8; i++) begin
      sclk_in = 0; repeat (20) @(negedge clk);
      sclk_in = 1; repeat (20) @(negedge clk);
    end
    repeat (2 * XFER) @(negedge clk);
    rd(SC_ADDR, v); chk("noext_stuck_busy", v, 8'hFE);
    chk("noext_no_irq", irq_n - n0, 0);
    wr(SC_ADDR, 8'h00);
    rd(SC_ADDR, v); chk("noext_abort", v, 8'h7E);
`endif
    chk("irq_pending", irq_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
